rv32i_encoder: RTL and testbench
================================

Name: rv32i_encoder

Overview:
Inverse of the RV32I Decoder. It accepts decoded instruction fields over a valid/ready input and emits the 32-bit machine word over a registered valid/ready output, together with the byte address the word is loaded to. The block feeds the instruction-memory loader and bench program generators, and gives a round-trip check against the Decoder. It range-checks immediates, flags illegal requests, and keeps address and error counters.

Parameters:
ADDR_BASE, 32'h0000_0000, address assigned to the first emitted word after reset or clear
CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous: reload address, zero the error counter, drop any held output
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
opcode  input  7  opcode field, passed through unchecked
rd, rs1, rs2  input  5 each  register indices
funct3  input  3  funct3
funct7  input  7  funct7 (R-type and I-type shifts)
imm  input  32  signed byte-offset immediate; for U-type, the full 32-bit value
out_valid  output  1  instr/addr/err valid
out_ready  input  1  downstream accepts
instr  output  32  encoded word
addr  output  32  load address of instr
err  output  1  bundle was illegal; instr forced to NOP
err_count  output  CNT_W  saturating count of illegal bundles emitted

Behaviour:
- Reset (async, rst_n=0): out_valid=0, instr=0, addr=ADDR_BASE, err=0, err_count=0, and the internal next-address register = ADDR_BASE.
- Pipeline:
  - Single output register stage with 1-cycle latency.
  - in_ready = !out_valid || out_ready (combinational).
  - A bundle is accepted when in_valid && in_ready.
  - Back-to-back throughput is 1 word per cycle.
- Output hold: while out_valid && !out_ready, instr, addr and err are held stable.
- Address: each accepted bundle takes addr = next-address, then next-address += 4, wrapping modulo 2^32.
- Field packing (bit 31 first):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode
  - I: imm[11:0] | rs1 | funct3 | rd | opcode
  - I-shift (fmt=I, opcode=0010011, funct3 = 001 or 101): funct7 | imm[4:0] | rs1 | funct3 | rd | opcode
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  - U: imm[31:12] | rd | opcode
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode
- Illegal conditions:
  - fmt = 6 or 7.
  - I/S: imm not representable as signed 12-bit.
  - I-shift: imm[31:5] != 0.
  - B: imm not signed 13-bit, or imm[0] = 1.
  - J: imm not signed 21-bit, or imm[0] = 1.
  - U: imm[11:0] != 0.
- On illegal bundle:
  - instr = 32'h0000_0013 (addi x0,x0,0), err = 1.
  - The address still advances.
  - err_count increments when the word is accepted by downstream, saturating at all-ones.
- clear:
  - Forces out_valid=0 and next-address=ADDR_BASE, and sets addr=ADDR_BASE and err_count=0.
  - in_ready=0 in the clear cycle; any input bundle that cycle is discarded.
  - clear has priority over all handshakes.
- Simultaneous out handshake and new accept: the output register is replaced by the new bundle in the same edge, with no bubble.
- Reset mid-transfer: the held word is lost and out_valid drops immediately (asynchronous).

Decomposition:
- Package rv32i_pkg holds:
  - the fmt enum (FMT_R..FMT_J);
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG);
  - NOP_WORD = 32'h0000_0013.
  The Decoder also imports this package.
- One combinational sub-module, rv32i_encode_fields, takes fmt and the fields and produces the packed word and the illegal flag. The top level holds the handshake register, address counter and error counter.

Test Plan:
- Add: fmt=R, op=0110011, rd=1, rs1=2, rs2=3, f3=0, f7=0 -> instr=0x003100B3 at addr=ADDR_BASE one cycle later; err=0.
- I-type stream, back-to-back with out_ready=1:
  - addi x1,x2,1 -> 0x00110093
  - sw x1,0(x2) -> 0x00112023 (fmt=S, op=0100011, f3=010)
  - srai x1,x2,1 (f7=0100000, imm=1) -> 0x40115093
  - addr runs 0,4,8; one word per cycle.
- Branch and jump:
  - beq x1,x2,+8 -> 0x00208463
  - jal x1,+16 -> 0x010000EF
  - beq with imm=3 -> instr=0x00000013, err=1, err_count=1 after accept.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr/addr stable; on release, the next word follows the very next cycle.
- Range checks: I-type imm=2048 -> err=1; imm=-2048 -> err=0 with imm field 0x800. U-type imm=0x12345001 -> err=1.
- Clear and reset:
  - clear pulse after 3 words -> out_valid=0, next word at ADDR_BASE, err_count=0.
  - rst_n low while out_valid=1 -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes and the canonical NOP.
// Imported by both the encoder and the decoder.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when v sign-extends from a bits-wide signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits - 1 && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/rv32i_encode_fields.sv
// Combinational packer: turns decoded fields into a 32-bit RV32I word and flags
// bundles whose format or immediate cannot be encoded.
module rv32i_encode_fields
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [31:0] raw;
  logic        bad;
  logic        is_shift;

  always_comb begin
    raw      = '0;
    bad      = 1'b0;
    is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    case (fmt)
      FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift) begin
          raw = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          bad = |imm[31:5];
        end else begin
          raw = {imm[11:0], rs1, funct3, rd, opcode};
          bad = !fits_signed(imm, 12);
        end
      end
      FMT_S: begin
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad = !fits_signed(imm, 12);
      end
      FMT_B: begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad = !fits_signed(imm, 13) || imm[0];
      end
      FMT_U: begin
        raw = {imm[31:12], rd, opcode};
        bad = |imm[11:0];
      end
      FMT_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad = !fits_signed(imm, 21) || imm[0];
      end
      default: bad = 1'b1;
    endcase
    word    = bad ? NOP_WORD : raw;
    illegal = bad;
  end

endmodule

// File: rtl/rv32i_encoder.sv
// RV32I encoder: accepts field bundles, emits encoded words through a single
// registered valid/ready stage with load address and a saturating error count.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [31:0]      addr,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      enc_word;
  logic             enc_illegal;
  logic             accept;
  logic             out_fire;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]      next_addr_q, next_addr_d;

  rv32i_encode_fields u_fields (
    .fmt     (fmt),
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_comb begin
    in_ready    = !clear && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    out_fire    = out_valid_q && out_ready;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    next_addr_d = next_addr_q;
    if (clear) begin
      out_valid_d = 1'b0;
      addr_d      = ADDR_BASE;
      next_addr_d = ADDR_BASE;
      err_count_d = '0;
      err_d       = 1'b0;
    end else begin
      // Errors are counted as they leave, so a dropped word is never counted.
      if (out_fire && err_q && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
      if (accept) begin
        out_valid_d = 1'b1;
        instr_d     = enc_word;
        addr_d      = next_addr_q;
        err_d       = enc_illegal;
        next_addr_d = next_addr_q + 32'd4;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= ADDR_BASE;
      err_q       <= 1'b0;
      err_count_q <= '0;
      next_addr_q <= ADDR_BASE;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      next_addr_q <= next_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign addr      = addr_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed bench for rv32i_encoder: hand-encoded vectors checked with immediate
// assertions, covering streaming, backpressure, range errors, clear and reset.
module tb_rv32i_encoder;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;
  logic [15:0] err_count;

  int total;
  int bad;

  rv32i_encoder #(
    .ADDR_BASE (32'h0000_0000),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .addr      (addr),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    in_valid = 1'b1;
    fmt      = f;
    opcode   = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    funct3   = f3;
    funct7   = f7;
    imm      = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] i, input logic [31:0] a,
                            input logic e);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".instr"}, instr, i);
    check({tag, ".addr"}, addr, a);
    check({tag, ".err"}, {31'b0, err}, {31'b0, e});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    #12;
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.instr", instr, 32'd0);
    check("rst.addr", addr, 32'd0);
    check("rst.err", {31'b0, err}, 32'd0);
    check("rst.cnt", {16'b0, err_count}, 32'd0);
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // add x1,x2,x3
    drive(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    tick();
    expect_out("add", 32'h003100B3, 32'd0, 1'b0);

    // Restart addressing so the stream lands at 0,4,8
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("clr1.valid", {31'b0, out_valid}, 32'd0);

    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd1);
    tick();
    expect_out("addi", 32'h00110093, 32'd0, 1'b0);
    drive(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd1, 3'b010, 7'd0, 32'd0);
    tick();
    expect_out("sw", 32'h00112023, 32'd4, 1'b0);
    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd1);
    tick();
    expect_out("srai", 32'h40115093, 32'd8, 1'b0);

    drive(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8);
    tick();
    expect_out("beq8", 32'h00208463, 32'd12, 1'b0);
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd16);
    tick();
    expect_out("jal16", 32'h010000EF, 32'd16, 1'b0);
    drive(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
    tick();
    expect_out("beq3", 32'h00000013, 32'd20, 1'b1);
    check("beq3.cnt", {16'b0, err_count}, 32'd0);

    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd2048);
    tick();
    expect_out("i2048", 32'h00000013, 32'd24, 1'b1);
    check("i2048.cnt", {16'b0, err_count}, 32'd1);
    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800);
    tick();
    expect_out("im2048", 32'h80010093, 32'd28, 1'b0);
    check("im2048.cnt", {16'b0, err_count}, 32'd2);
    drive(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001);
    tick();
    expect_out("u_bad", 32'h00000013, 32'd32, 1'b1);
    drive(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000);
    tick();
    expect_out("lui", 32'h123450B7, 32'd36, 1'b0);
    check("lui.cnt", {16'b0, err_count}, 32'd3);
    in_valid = 1'b0;
    tick();
    check("idle.valid", {31'b0, out_valid}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd5);
    tick();
    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd6);
    for (int k = 0; k < 3; k++) begin
      check("bp.in_ready", {31'b0, in_ready}, 32'd0);
      expect_out("bp.hold", 32'h00510093, 32'd40, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    expect_out("bp.next", 32'h00610093, 32'd44, 1'b0);

    // Three words, then clear with a bundle present that must be discarded
    drive(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    tick();
    tick();
    tick();
    expect_out("pre_clr", 32'h003100B3, 32'd56, 1'b0);
    check("pre_clr.cnt", {16'b0, err_count}, 32'd3);
    clear = 1'b1;
    #1;
    check("clr.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    clear = 1'b0;
    check("clr.valid", {31'b0, out_valid}, 32'd0);
    check("clr.addr", addr, 32'd0);
    check("clr.cnt", {16'b0, err_count}, 32'd0);
    drive(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd1);
    tick();
    expect_out("post_clr", 32'h00110093, 32'd0, 1'b0);

    // Asynchronous reset while a word is held
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    check("mid.valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {31'b0, out_valid}, 32'd0);
    check("arst.instr", instr, 32'd0);
    check("arst.addr", addr, 32'd0);
    check("arst.err", {31'b0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
